// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults, channel state type and clock-threshold helper for clk_div_bank
package clk_div_pkg;
  localparam int NCH_DEF = 4;
  localparam int CW_DEF = 16;
  localparam int RST_DIV_DEF = 2;
  localparam int MAX_CW = 32;
  typedef struct packed {
    logic [MAX_CW-1:0] d;
    logic [MAX_CW-1:0] s;
    logic [MAX_CW-1:0] cnt;
    logic p;
  } chan_state_t;
  function automatic logic [MAX_CW-1:0] half_thr(input logic [MAX_CW-1:0] d);
    return d >> 1;
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with shadowed divisor applied only at period wrap or sync
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int RST_DIV = RST_DIV_DEF
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          adv,
  input  logic          sync,
  input  logic          wr,
  input  logic [CW-1:0] val,
  output logic          wrap,
  output logic          clk_out
);
  chan_state_t st;
  logic [MAX_CW-1:0] s_new;
  logic p_new;
  // fold a same-cycle write into the shadow so a coinciding wrap or sync picks it up
  always_comb begin
    s_new = wr ? MAX_CW'(val) : st.s;
    p_new = wr | st.p;
    wrap = adv && (st.cnt == st.d - MAX_CW'(1));
  end
  // counter, divisor swap at wrap/sync, and registered square wave
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      st.d <= MAX_CW'(RST_DIV);
      st.s <= MAX_CW'(RST_DIV);
      st.cnt <= '0;
      st.p <= 1'b0;
      clk_out <= 1'b0;
    end else if (sync) begin
      st.d <= p_new ? s_new : st.d;
      st.s <= s_new;
      st.cnt <= '0;
      st.p <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      st.s <= s_new;
      st.p <= wrap ? 1'b0 : p_new;
      if (wrap && p_new) st.d <= s_new;
      if (adv) begin
        st.cnt <= wrap ? '0 : st.cnt + MAX_CW'(1);
        clk_out <= st.cnt >= half_thr(st.d);
      end
    end
  end
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NCH programmable clock dividers; define CLK_DIV_BANK_CASCADE_EN to chain channels
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW = CW_DEF,
  parameter int RST_DIV = RST_DIV_DEF
) (
  input  logic                               sys_clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               sync_req,
  input  logic                               div_wr,
  input  logic [$clog2(NCH > 1 ? NCH : 2)-1:0] div_sel,
  input  logic [CW-1:0]                      div_val,
  output logic                               div_ack,
  output logic                               div_err,
  output logic [NCH-1:0]                     clk_out,
  output logic [NCH-1:0]                     stb_out
);
  logic [NCH-1:0] wrap, wr;
  logic good;
  // accept only nonzero divisors aimed at an existing channel
  always_comb begin
    good = div_wr && (32'(div_sel) < 32'(NCH)) && (div_val != '0);
    for (int k = 0; k < NCH; k++) wr[k] = good && (32'(div_sel) == 32'(k));
  end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic a, w;
`ifdef CLK_DIV_BANK_CASCADE_EN
    if (i == 0) begin : g_head
      assign a = enable;
    end else begin : g_link
      assign a = g_ch[i-1].w;
    end
`else
    assign a = enable;
`endif
    clk_div_chan #(.CW(CW), .RST_DIV(RST_DIV)) u_chan (
      .sys_clk(sys_clk),
      .reset(reset),
      .adv(a),
      .sync(sync_req),
      .wr(wr[i]),
      .val(div_val),
      .wrap(w),
      .clk_out(clk_out[i])
    );
    assign wrap[i] = w;
  end
  // write acknowledge and terminal-count strobes, one cycle after the event
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      div_ack <= 1'b0;
      div_err <= 1'b0;
      stb_out <= '0;
    end else begin
      div_ack <= div_wr;
      div_err <= div_wr && !good;
      stb_out <= sync_req ? '0 : wrap;
    end
  end
endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of independent divider channels (1..16).
REQ-002 SHALL have parameter CW, default 16, meaning divisor/counter width in bits (2..32).
REQ-003 SHALL have parameter RST_DIV, default 2, meaning divisor loaded into every channel at reset.
REQ-004 SHALL have port sys_clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have port enable, input, 1, global count enable; low freezes all counters.
REQ-007 SHALL have port sync_req, input, 1, single-cycle pulse realigning all channels.
REQ-008 SHALL have port div_wr, input, 1, single-cycle divisor write strobe.
REQ-009 SHALL have port div_sel, input, max(1,$clog2(NCH)), target channel of the write.
REQ-010 SHALL have port div_val, input, CW, new divisor value.
REQ-011 SHALL have port div_ack, output, 1, one-cycle write acknowledge.
REQ-012 SHALL have port div_err, output, 1, valid with div_ack; 1 = write rejected.
REQ-013 SHALL have port clk_out, output, NCH, registered divided square waves.
REQ-014 SHALL have port stb_out, output, NCH, registered one-cycle terminal-count strobes.

Function
REQ-015 Each channel SHALL hold active divisor D, shadow divisor S, pending flag P, and counter cnt (CW bits) counting 0..D-1 once per advance tick.
REQ-016 Advance tick SHALL be enable=1 on a clock edge (cascade rules in REQ-030).
REQ-017 stb_out[k] SHALL be 1 for exactly the cycle after the tick where cnt==D-1; cnt then wraps to 0.
REQ-018 clk_out[k] SHALL be low while cnt < floor(D/2) and high otherwise, registered (one-cycle latency from cnt); D=1 gives constant high, odd D gives high for ceil(D/2) ticks.
REQ-019 A div_wr with div_val==0 SHALL be rejected: next cycle div_ack=1, div_err=1, channel state unchanged.
REQ-020 A div_wr with div_val>=1 SHALL store S, set P, and pulse div_ack=1, div_err=0 the next cycle.
REQ-021 When P is set, S SHALL become D at the next wrap (cnt==D-1 tick), clearing P; the running period is never truncated or glitched.
REQ-022 Repeated writes to one channel before wrap SHALL leave only the last value in S.
REQ-023 A div_sel >= NCH SHALL be rejected with div_err=1.
REQ-024 sync_req SHALL, on the next edge, clear every cnt to 0, drive clk_out low and stb_out low, and load D=S for channels with P set, regardless of enable.
REQ-025 div_wr coincident with sync_req SHALL have its value applied by that same sync.
REQ-026 enable=0 SHALL hold cnt and clk_out and force stb_out to 0; writes are still accepted.
REQ-027 With enable held high and no cascade, channel with divisor D SHALL assert stb_out exactly every D cycles, first at cycle D after reset release.

Reset
REQ-028 On a sys_clk edge with reset=0: cnt=0, D=S=RST_DIV, P=0, clk_out=0, stb_out=0, div_ack=0, div_err=0; any in-flight write is discarded.

Configuration
REQ-029 Macro CLK_DIV_BANK_CASCADE_EN SHALL select cascade mode at compile time.
REQ-030 Defined: channel k>0 SHALL advance only on cycles where channel k-1 wraps (enable=1), channel 0 as REQ-016; total division of channel k is the product of D0..Dk. Undefined: all channels advance per REQ-016 independently.

Structure
REQ-031 Package clk_div_pkg SHALL hold default parameter constants, the channel-state typedef, and the floor-half threshold function.
REQ-032 Per-channel logic SHALL be sub-module clk_div_chan, instanced NCH times via generate; write decode and div_ack/div_err live in the top.

Verification
REQ-033 Reset, enable=1, RST_DIV=2: all stb_out pulse at cycles 2,4,6; clk_out toggles every cycle.
REQ-034 Write ch1 D=5 mid-period: div_ack at +1 cycle; old period completes, then stb every 5 cycles, clk_out low 2/high 3.
REQ-035 Write D=0 and div_sel=NCH: div_ack=1, div_err=1, periods unchanged.
REQ-036 Pending write ch2 D=7 plus sync_req same cycle: all cnt=0 next cycle, ch2 stb every 7 cycles thereafter.
REQ-037 enable low 10 cycles mid-period: no stb_out, clk_out frozen, phase resumes exactly.
REQ-038 With CLK_DIV_BANK_CASCADE_EN, D0=4, D1=3: stb_out[1] every 12 cycles, coincident with every third stb_out[0].
